// File: rtl/router_a.sv
// router_a -- input router for the Kalman filter datapath.
//
// Selects the word written to the register file, the two register-file
// address ports and the write enable. Sources are the external bus
// (DATA_IN, DIR, WRITE, READY), the arithmetic unit (result) and the
// control FSM (ctl_a, ctl_b, sel_*).
//
// Configuration macro: ROUTER_A_REG_OUT_EN
//   undefined : outputs are purely combinational; CLK and RST are ignored.
//   defined   : outputs are registered on CLK rising edge (1-cycle latency),
//               RST asynchronously clears them to 0.
//
// Ports
//   CLK, RST   clock / async active-high reset (registered build only)
//   DATA_IN    external data word            [W]
//   result     arithmetic unit result        [W]
//   ctl_a/b    FSM addresses for ports A/B   [ADDRW]
//   DIR        external address              [ADDRW]
//   WRITE      external write request
//   READY      external ready qualifier
//   sel_data   data source   : 0 DATA_IN, 1 result, 2 zeros, 3 ones
//   sel_dira   port A address: 0 ctl_a, 1 DIR
//   sel_dirb   port B address: 0 ctl_b, 1 DIR
//   sel_write  write mode    : 0 WRITE, 1 WRITE&READY, 2 off, 3 on
//   data, dira, dirb, write    routed outputs
module router_a #(
    parameter int W     = 24,
    parameter int ADDRW = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     DATA_IN,
    input  logic [W-1:0]     result,
    input  logic [ADDRW-1:0] ctl_a,
    input  logic [ADDRW-1:0] ctl_b,
    input  logic [ADDRW-1:0] DIR,
    input  logic             WRITE,
    input  logic             READY,
    input  logic [1:0]       sel_data,
    input  logic             sel_dira,
    input  logic             sel_dirb,
    input  logic [1:0]       sel_write,
    output logic [W-1:0]     data,
    output logic [ADDRW-1:0] dira,
    output logic [ADDRW-1:0] dirb,
    output logic             write
);

    logic [W-1:0]     data_d;
    logic [ADDRW-1:0] dira_d;
    logic [ADDRW-1:0] dirb_d;
    logic             write_d;

    // Case-based muxing only evaluates the selected source, so X/Z on an
    // unselected input never reaches the outputs.
    always_comb begin
        data_d  = '0;
        dira_d  = '0;
        dirb_d  = '0;
        write_d = 1'b0;

        case (sel_data)
            2'd0:    data_d = DATA_IN;
            2'd1:    data_d = result;
            2'd2:    data_d = '0;
            default: data_d = '1;
        endcase

        case (sel_dira)
            1'b0:    dira_d = ctl_a;
            default: dira_d = DIR;
        endcase

        case (sel_dirb)
            1'b0:    dirb_d = ctl_b;
            default: dirb_d = DIR;
        endcase

        case (sel_write)
            2'd0:    write_d = WRITE;
            2'd1:    write_d = WRITE & READY;
            2'd2:    write_d = 1'b0;
            default: write_d = 1'b1;
        endcase
    end

`ifdef ROUTER_A_REG_OUT_EN
    logic [W-1:0]     data_q;
    logic [ADDRW-1:0] dira_q;
    logic [ADDRW-1:0] dirb_q;
    logic             write_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q  <= '0;
            dira_q  <= '0;
            dirb_q  <= '0;
            write_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            dira_q  <= dira_d;
            dirb_q  <= dirb_d;
            write_q <= write_d;
        end
    end

    assign data  = data_q;
    assign dira  = dira_q;
    assign dirb  = dirb_q;
    assign write = write_q;
`else
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;

    assign data  = data_d;
    assign dira  = dira_d;
    assign dirb  = dirb_d;
    assign write = write_d;
`endif

endmodule

// File: tb/tb_router_a.sv
// tb_router_a -- directed self-checking bench for router_a.
module tb_router_a;

    localparam int W     = 24;
    localparam int ADDRW = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic [W-1:0]     DATA_IN;
    logic [W-1:0]     result;
    logic [ADDRW-1:0] ctl_a;
    logic [ADDRW-1:0] ctl_b;
    logic [ADDRW-1:0] DIR;
    logic             WRITE;
    logic             READY;
    logic [1:0]       sel_data;
    logic             sel_dira;
    logic             sel_dirb;
    logic [1:0]       sel_write;
    logic [W-1:0]     data;
    logic [ADDRW-1:0] dira;
    logic [ADDRW-1:0] dirb;
    logic             write;

    int tests = 0;
    int fails = 0;

    // Hand-computed expectations.
    logic [W-1:0] data_tab [4];
    // write expectation indexed by {sel_write, WRITE, READY}
    logic [15:0]  write_tab;
    logic [7:0]   vec;
    logic [3:0]   widx;

    router_a #(.W(W), .ADDRW(ADDRW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DATA_IN   (DATA_IN),
        .result    (result),
        .ctl_a     (ctl_a),
        .ctl_b     (ctl_b),
        .DIR       (DIR),
        .WRITE     (WRITE),
        .READY     (READY),
        .sel_data  (sel_data),
        .sel_dira  (sel_dira),
        .sel_dirb  (sel_dirb),
        .sel_write (sel_write),
        .data      (data),
        .dira      (dira),
        .dirb      (dirb),
        .write     (write)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Let new inputs reach the outputs: one clock edge in the registered
    // build, a short delay otherwise. Sampling is 1 ns after the edge.
    task automatic settle();
`ifdef ROUTER_A_REG_OUT_EN
        @(posedge CLK);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        data_tab[0] = 24'h123456;
        data_tab[1] = 24'hC0FFEE;
        data_tab[2] = 24'h000000;
        data_tab[3] = 24'hFFFFFF;
        write_tab   = 16'hF08C;

        RST       = 1'b1;
        DATA_IN   = 24'h123456;
        result    = 24'hC0FFEE;
        ctl_a     = 5'h03;
        ctl_b     = 5'h1C;
        DIR       = 5'h12;
        WRITE     = 1'b1;
        READY     = 1'b1;
        sel_data  = 2'd1;
        sel_dira  = 1'b1;
        sel_dirb  = 1'b0;
        sel_write = 2'd3;
        #2;

`ifdef ROUTER_A_REG_OUT_EN
        chk("reset_data",  32'(data),  32'h0);
        chk("reset_dira",  32'(dira),  32'h0);
        chk("reset_dirb",  32'(dirb),  32'h0);
        chk("reset_write", 32'(write), 32'h0);
`else
        // RST has no effect on the combinational outputs.
        chk("rst_ignored_data",  32'(data),  32'hC0FFEE);
        chk("rst_ignored_dira",  32'(dira),  32'h12);
        chk("rst_ignored_dirb",  32'(dirb),  32'h1C);
        chk("rst_ignored_write", 32'(write), 32'h1);
`endif
        RST = 1'b0;

        // Directed spot checks.
        sel_data = 2'd0; sel_dira = 1'b0; sel_dirb = 1'b1; sel_write = 2'd1;
        WRITE = 1'b1; READY = 1'b0;
        settle();
        chk("dir_data_din",   32'(data),  32'h123456);
        chk("dir_dira_ctl",   32'(dira),  32'h03);
        chk("dir_dirb_dir",   32'(dirb),  32'h12);
        chk("dir_write_nrdy", 32'(write), 32'h0);

        READY = 1'b1; sel_data = 2'd3;
        settle();
        chk("dir_data_ones", 32'(data),  32'hFFFFFF);
        chk("dir_write_rdy", 32'(write), 32'h1);

        // X/Z on unselected sources must not leak through.
        result = 'x; DIR = 'z; READY = 1'bx;
        sel_data = 2'd0; sel_dira = 1'b0; sel_dirb = 1'b0; sel_write = 2'd2;
        settle();
        chk("x_data",  32'(data),  32'h123456);
        chk("x_dira",  32'(dira),  32'h03);
        chk("x_dirb",  32'(dirb),  32'h1C);
        chk("x_write", 32'(write), 32'h0);
        result = 24'hC0FFEE; DIR = 5'h12; READY = 1'b0;

        // Exhaustive select/qualifier sweep.
        for (int v = 0; v < 256; v++) begin
            vec = 8'(v);
            {sel_data, sel_dira, sel_dirb, sel_write, WRITE, READY} = vec;
            widx = {sel_write, WRITE, READY};
            settle();
            chk($sformatf("sweep%0d_data", v),  32'(data),  32'(data_tab[sel_data]));
            chk($sformatf("sweep%0d_dira", v),  32'(dira),  sel_dira ? 32'h12 : 32'h03);
            chk($sformatf("sweep%0d_dirb", v),  32'(dirb),  sel_dirb ? 32'h12 : 32'h1C);
            chk($sformatf("sweep%0d_write", v), 32'(write), 32'(write_tab[widx]));
        end

`ifdef ROUTER_A_REG_OUT_EN
        // Mid-run asynchronous reset, held across an edge, then release.
        sel_data = 2'd3; sel_dira = 1'b1; sel_dirb = 1'b1; sel_write = 2'd3;
        settle();
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_data",  32'(data),  32'h0);
        chk("midrst_dira",  32'(dira),  32'h0);
        chk("midrst_dirb",  32'(dirb),  32'h0);
        chk("midrst_write", 32'(write), 32'h0);
        @(posedge CLK);
        #1;
        chk("hold_rst_data",  32'(data),  32'h0);
        chk("hold_rst_write", 32'(write), 32'h0);
        #2;
        RST = 1'b0;
        sel_data = 2'd1;
        #1;
        chk("pre_edge_data", 32'(data), 32'h0);
        @(posedge CLK);
        #1;
        chk("post_rst_data",  32'(data),  32'hC0FFEE);
        chk("post_rst_dira",  32'(dira),  32'h12);
        chk("post_rst_write", 32'(write), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
